// File: rtl/zstr_pkg.sv
// Shared types and default widths for the z-stream source and its queues.
package zstr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        VALID
    } zstr_gen_st_t;

    localparam int ZSTR_TW = 16;
    localparam int ZSTR_DW = 8;

endpackage

// File: rtl/zstr_fifo.sv
// Synchronous FIFO with depth wrapping modulo D (any D >= 1); exposes the head and the slot after it.
// A push while full is accepted only when a pop happens in the same cycle.
module zstr_fifo #(
    parameter int W  = 8,
    parameter int D  = 4,
    parameter int CW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    output logic [W-1:0]  o_rdata,
    output logic [W-1:0]  o_nxt,
    output logic [CW-1:0] o_cnt,
    output logic          o_full,
    output logic          o_empty
);

    localparam int PW = (D > 1) ? $clog2(D) : 1;

    logic [W-1:0]  r_mem [D];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] w_wptr_inc;
    logic [PW-1:0] w_rptr_inc;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_wptr_inc = (r_wptr == PW'(D - 1)) ? '0 : r_wptr + 1'b1;
    assign w_rptr_inc = (r_rptr == PW'(D - 1)) ? '0 : r_rptr + 1'b1;

    assign o_full    = (r_cnt == CW'(D));
    assign o_empty   = (r_cnt == '0);
    assign o_cnt     = r_cnt;
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    assign o_rdata = r_mem[r_rptr];
    assign o_nxt   = r_mem[w_rptr_inc];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_do_push) r_wptr <= w_wptr_inc;
            if (w_do_pop)  r_rptr <= w_rptr_inc;
            if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_do_push && w_do_pop) r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/zstr_gen.sv
// z-stream source: queued entries are driven onto z_vld/z_bus after their pre-delay, ready-wait cycles are queued.
// Optional ZSTR_GEN_IDLE_XZ_EN drives {BW{XZ}} on z_bus whenever z_vld is low.
//   state | meaning
//   IDLE  | no entry in flight, waiting for the entry queue to be non-empty
//   DELAY | head entry taken, counting down its pre-delay
//   VALID | head entry on the bus, waiting for z_rdy
module zstr_gen
    import zstr_pkg::*;
#(
    parameter int   BW = 8,
    parameter logic XZ = 1'bx,
    parameter int   QL = 4,
    parameter int   QW = $clog2(QL + 1),
    parameter int   DW = ZSTR_DW,
    parameter int   TW = ZSTR_TW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p_vld,
    input  logic [BW-1:0] p_bus,
    input  logic [DW-1:0] p_dly,
    output logic          p_rdy,
    output logic          z_vld,
    output logic [BW-1:0] z_bus,
    input  logic          z_rdy,
    output logic          t_vld,
    output logic [TW-1:0] t_tmg,
    input  logic          t_rdy,
    output logic [QW-1:0] q_cnt,
    output logic          t_ovf
);

    zstr_gen_st_t     r_st;
    logic [DW-1:0]    r_dcnt;
    logic [TW-1:0]    r_wcnt;
    logic             r_ovf;

    logic [BW+DW-1:0] w_head;
    logic [BW+DW-1:0] w_next;
    logic [DW-1:0]    w_head_dly;
    logic [DW-1:0]    w_next_dly;
    logic [BW-1:0]    w_head_bus;
    logic             w_q_full;
    logic             w_q_empty;
    logic             w_p_trn;
    logic             w_z_trn;
    logic [TW-1:0]    w_t_nxt;
    logic [QW-1:0]    w_t_cnt;
    logic             w_t_full;
    logic             w_t_empty;
    logic             w_t_pop;
    logic             w_unused;

    // No pass-through: a full queue refuses puts even when the head pops.
    assign p_rdy   = rst_n & ~w_q_full;
    assign w_p_trn = p_vld & p_rdy;
    assign z_vld   = (r_st == VALID);
    assign w_z_trn = z_vld & z_rdy;

    assign w_head_dly = w_head[DW-1:0];
    assign w_head_bus = w_head[BW+DW-1:DW];
    assign w_next_dly = w_next[DW-1:0];

    zstr_fifo #(.W(BW + DW), .D(QL), .CW(QW)) u_ent_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_p_trn),
        .i_wdata ({p_bus, p_dly}),
        .i_pop   (w_z_trn),
        .o_rdata (w_head),
        .o_nxt   (w_next),
        .o_cnt   (q_cnt),
        .o_full  (w_q_full),
        .o_empty (w_q_empty)
    );

    assign w_t_pop = t_vld & t_rdy;
    assign t_vld   = ~w_t_empty;
    assign t_ovf   = r_ovf;

    zstr_fifo #(.W(TW), .D(QL), .CW(QW)) u_tmg_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_z_trn),
        .i_wdata (r_wcnt),
        .i_pop   (w_t_pop),
        .o_rdata (t_tmg),
        .o_nxt   (w_t_nxt),
        .o_cnt   (w_t_cnt),
        .o_full  (w_t_full),
        .o_empty (w_t_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st   <= IDLE;
            r_dcnt <= '0;
            r_wcnt <= '0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_st)
                IDLE: begin
                    if (!w_q_empty) begin
                        if (w_head_dly == '0) begin
                            r_st <= VALID;
                        end else begin
                            r_st   <= DELAY;
                            r_dcnt <= w_head_dly - 1'b1;
                        end
                    end
                end
                DELAY: begin
                    if (r_dcnt == '0) r_st   <= VALID;
                    else              r_dcnt <= r_dcnt - 1'b1;
                end
                VALID: begin
                    if (z_rdy) begin
                        if (q_cnt > QW'(1)) begin
                            if (w_next_dly == '0) begin
                                r_st <= VALID;
                            end else begin
                                r_st   <= DELAY;
                                r_dcnt <= w_next_dly - 1'b1;
                            end
                        end else begin
                            r_st <= IDLE;
                        end
                    end
                end
                default: r_st <= IDLE;
            endcase

            if (w_z_trn)                                r_wcnt <= '0;
            else if (r_st == VALID && r_wcnt != '1)     r_wcnt <= r_wcnt + 1'b1;

            if (w_z_trn && w_t_full && !w_t_pop) r_ovf <= 1'b1;
        end
    end

`ifdef ZSTR_GEN_IDLE_XZ_EN
    assign z_bus    = z_vld ? w_head_bus : {BW{XZ}};
    assign w_unused = ^{w_t_nxt, w_t_cnt};
`else
    assign z_bus    = w_head_bus;
    assign w_unused = ^{w_t_nxt, w_t_cnt, XZ};
`endif

endmodule

// File: tb/tb_zstr_gen.sv
// Directed bench for zstr_gen: latency, pre-delay, back-to-back, timing overflow and async reset.
module tb_zstr_gen;

    localparam int BW = 8;
    localparam int QL = 4;
    localparam int QW = 3;
    localparam int DW = 8;
    localparam int TW = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          p_vld = 1'b0;
    logic [BW-1:0] p_bus = '0;
    logic [DW-1:0] p_dly = '0;
    logic          z_rdy = 1'b0;
    logic          t_rdy = 1'b0;
    logic          p_rdy;
    logic          z_vld;
    logic [BW-1:0] z_bus;
    logic          t_vld;
    logic [TW-1:0] t_tmg;
    logic [QW-1:0] q_cnt;
    logic          t_ovf;

    int n_tot = 0;
    int n_bad = 0;
    int t3_exp [4] = '{2, 0, 0, 0};

    always #5 clk = ~clk;

    zstr_gen #(.BW(BW), .QL(QL), .QW(QW), .DW(DW), .TW(TW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .p_vld (p_vld),
        .p_bus (p_bus),
        .p_dly (p_dly),
        .p_rdy (p_rdy),
        .z_vld (z_vld),
        .z_bus (z_bus),
        .z_rdy (z_rdy),
        .t_vld (t_vld),
        .t_tmg (t_tmg),
        .t_rdy (t_rdy),
        .q_cnt (q_cnt),
        .t_ovf (t_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_p_rdy", 32'(p_rdy), 0);
        chk("rst_z_vld", 32'(z_vld), 0);
        chk("rst_q_cnt", 32'(q_cnt), 0);
        chk("rst_t_vld", 32'(t_vld), 0);
        chk("rst_t_ovf", 32'(t_ovf), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_p_rdy", 32'(p_rdy), 1);

        // dly=0 entry into an idle block: z_vld in cycle 2 only
        z_rdy = 1'b1; p_vld = 1'b1; p_bus = 8'hA5; p_dly = 8'd0;
        tick(); p_vld = 1'b0;
        chk("t1_c1_vld", 32'(z_vld), 0);
        chk("t1_c1_qcnt", 32'(q_cnt), 1);
        tick();
        chk("t1_c2_vld", 32'(z_vld), 1);
        chk("t1_c2_bus", 32'(z_bus), 32'hA5);
        tick();
        chk("t1_c3_vld", 32'(z_vld), 0);
        chk("t1_t_vld", 32'(t_vld), 1);
        chk("t1_t_tmg", 32'(t_tmg), 0);
        t_rdy = 1'b1; tick(); t_rdy = 1'b0;
        chk("t1_t_empty", 32'(t_vld), 0);

        // dly=3, five stalled valid cycles
        z_rdy = 1'b0; p_vld = 1'b1; p_bus = 8'h11; p_dly = 8'd3;
        tick(); p_vld = 1'b0;
        tick(); tick(); tick();
        chk("t2_c4_vld", 32'(z_vld), 0);
`ifdef ZSTR_GEN_IDLE_XZ_EN
        chk("t2_dly_bus_x", 32'($isunknown(z_bus)), 1);
`else
        chk("t2_dly_bus", 32'(z_bus), 32'h11);
`endif
        tick();
        chk("t2_c5_vld", 32'(z_vld), 1);
        chk("t2_c5_bus", 32'(z_bus), 32'h11);
        repeat (5) tick();
        chk("t2_c10_vld", 32'(z_vld), 1);
        chk("t2_c10_tvld", 32'(t_vld), 0);
        z_rdy = 1'b1; tick(); z_rdy = 1'b0;
        chk("t2_c11_vld", 32'(z_vld), 0);
        chk("t2_t_vld", 32'(t_vld), 1);
        chk("t2_t_tmg", 32'(t_tmg), 5);
        t_rdy = 1'b1; tick(); t_rdy = 1'b0;

        // fill to QL, refused put while full, then back-to-back drain (slots wrap)
        for (int i = 0; i < 4; i++) begin
            p_vld = 1'b1; p_bus = 8'(8'h21 + i); p_dly = 8'd0;
            tick();
        end
        p_vld = 1'b0;
        chk("t3_full_qcnt", 32'(q_cnt), 4);
        chk("t3_full_prdy", 32'(p_rdy), 0);
        p_vld = 1'b1; p_bus = 8'hEE; z_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_b2b_vld", 32'(z_vld), 1);
            chk("t3_b2b_bus", 32'(z_bus), 32'h21 + i);
            tick();
            p_vld = 1'b0;
        end
        z_rdy = 1'b0;
        chk("t3_end_vld", 32'(z_vld), 0);
        chk("t3_end_qcnt", 32'(q_cnt), 0);
        t_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_tmg", 32'(t_tmg), 32'(t3_exp[i]));
            tick();
        end
        t_rdy = 1'b0;
        chk("t3_t_empty", 32'(t_vld), 0);

        // five transfers with waits 0..4 and no timing reads
        for (int k = 0; k < 5; k++) begin
            p_vld = 1'b1; p_bus = 8'(8'h30 + k); p_dly = 8'd0;
            tick(); p_vld = 1'b0;
            tick();
            repeat (k) tick();
            chk("t4_vld", 32'(z_vld), 1);
            chk("t4_bus", 32'(z_bus), 32'h30 + 32'(k));
            z_rdy = 1'b1; tick(); z_rdy = 1'b0;
            chk("t4_ovf", 32'(t_ovf), (k == 4) ? 32'd1 : 32'd0);
        end
        t_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_tmg", 32'(t_tmg), 32'(i));
            tick();
        end
        t_rdy = 1'b0;
        chk("t4_t_empty", 32'(t_vld), 0);
        chk("t4_ovf_sticky", 32'(t_ovf), 1);

        // async reset during DELAY with two entries queued
        p_vld = 1'b1; p_bus = 8'h41; p_dly = 8'd5;
        tick();
        p_bus = 8'h42; p_dly = 8'd0;
        tick(); p_vld = 1'b0;
        tick();
        chk("t5_pre_qcnt", 32'(q_cnt), 2);
        chk("t5_pre_vld", 32'(z_vld), 0);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_qcnt", 32'(q_cnt), 0);
        chk("t5_rst_vld", 32'(z_vld), 0);
        chk("t5_rst_prdy", 32'(p_rdy), 0);
        chk("t5_rst_ovf", 32'(t_ovf), 0);
        tick();
        rst_n = 1'b1;
        p_vld = 1'b1; p_bus = 8'h55; p_dly = 8'd0; z_rdy = 1'b1;
        tick(); p_vld = 1'b0;
        tick();
        chk("t5_vld", 32'(z_vld), 1);
        chk("t5_bus", 32'(z_bus), 32'h55);
        tick();
        z_rdy = 1'b0;
        chk("t5_end_vld", 32'(z_vld), 0);
        chk("t5_t_vld", 32'(t_vld), 1);
        chk("t5_t_tmg", 32'(t_tmg), 0);
        chk("t5_ovf", 32'(t_ovf), 0);
        chk("t5_qcnt", 32'(q_cnt), 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/zstr_gen.md
Name: zstr_gen

Overview:
- Parametrised z-stream source, next generation of the single-queue testbench source.
- Accepts entries on a put port. Each entry is bus data plus a programmable pre-delay of idle cycles.
- Drives each entry onto the z stream (vld/bus/rdy) after its pre-delay. Records the ready-wait cycles of every transfer into a timing queue, which is read through a get port.
- Sits between a bench sequencer and the DUT stream input; synthesisable, so it is also usable in FPGA traffic generators.

Parameters:
- BW, 8, z_bus width in bits.
- XZ, 1'bx, z_bus idle value (used only with the optional feature).
- QL, 4, depth of the entry queue and of the timing queue; any value ≥1, wraps modulo QL.
- QW, $clog2(QL+1), width of the occupancy counts.
- DW, 8, pre-delay field width.
- TW, 16, timing (wait-cycle) counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- p_vld  in  1  put entry valid
- p_bus  in  BW  put entry bus data
- p_dly  in  DW  put entry pre-delay (idle cycles before z_vld)
- p_rdy  out  1  put ready (entry queue not full)
- z_vld  out  1  stream transfer valid
- z_bus  out  BW  stream data
- z_rdy  in  1  stream transfer ready
- t_vld  out  1  timing entry available
- t_tmg  out  TW  wait cycles of the oldest unread transfer
- t_rdy  in  1  timing entry consumed
- q_cnt  out  QW  entry queue occupancy
- t_ovf  out  1  sticky timing-queue overflow flag

Behaviour:
- Reset (rst_n low, asynchronous, takes effect mid-cycle):
  - q_cnt=0, timing count=0, all pointers=0, state=IDLE.
  - z_vld=0, p_rdy=0 while rst_n is low; p_rdy=1 from the first cycle after release.
  - t_vld=0, t_ovf=0, wait counter=0.
  - Buffer contents are not reset. Entries in flight are discarded and no timing is recorded for them.
- Put:
  - p_trn = p_vld & p_rdy, where p_rdy = (q_cnt < QL).
  - When full, p_rdy=0 even if a pop occurs in the same cycle (no pass-through).
  - A simultaneous put and pop leaves q_cnt unchanged.
- State machine (registered), states IDLE / DELAY / VALID:
  - IDLE: if q_cnt>0, the head entry is taken. dly==0 -> VALID; dly>0 -> DELAY with dcnt=dly-1.
  - DELAY: z_vld=0. When dcnt==0 -> VALID, else dcnt decrements.
  - VALID: z_vld=1 and z_bus = head data, stable until the transfer. On z_trn = z_vld & z_rdy the head is popped, then:
    - q_cnt>1 and next dly==0 -> stay VALID (back-to-back, one transfer per cycle);
    - q_cnt>1 and next dly>0 -> DELAY with dcnt=dly-1;
    - otherwise -> IDLE.
- Latency: an entry put in cycle n into an empty, idle block asserts z_vld in cycle n+2+dly.
- z_vld never drops without a transfer; z_rdy while z_vld=0 is ignored.
- Wait counter:
  - Counts VALID cycles with z_rdy=0 and saturates at 2^TW-1.
  - On z_trn its current value (0 = accepted in the first valid cycle) is pushed to the timing queue, and the counter clears.
- Timing queue:
  - t_vld = (count>0); t_tmg = head entry; pop on t_vld & t_rdy.
  - A push and a pop in the same cycle are both honoured.
  - Push when full without a simultaneous pop: the new value is dropped and t_ovf is set (sticky until reset). The z transfer itself is never stalled.

Optional Feature:
- ZSTR_GEN_IDLE_XZ_EN defined: z_bus = {BW{XZ}} whenever z_vld=0, including during reset.
- Undefined: z_bus is always the head buffer slot, so data is stable during DELAY and after the last transfer; X in simulation before the first write.

Decomposition:
- Package zstr_pkg holds:
  - the state enum zstr_gen_st_t {IDLE, DELAY, VALID};
  - default-width constants ZSTR_TW=16 and ZSTR_DW=8.
- Sub-module zstr_fifo (parametrised width/depth synchronous FIFO, asynchronous active-low reset, count/full/empty outputs) is instantiated twice:
  - entry queue, width BW+DW;
  - timing queue, width TW.

Test Plan:
- Put {bus=8'hA5, dly=0} in cycle 0, z_rdy=1 -> z_vld=1 with z_bus=8'hA5 in cycle 2 only; then t_vld=1 with t_tmg=0.
- Put {8'h11,dly=3}, z_rdy held 0 for 5 valid cycles then 1 -> z_vld rises in cycle 5; t_tmg=5.
- QL=4, put 4 entries all dly=0 with z_rdy=0 -> p_rdy=0 after the 4th and q_cnt=4. Then z_rdy=1 -> 4 back-to-back transfers in consecutive cycles with data in put order; the read pointer wraps correctly on a second fill.
- t_rdy=0, perform 5 transfers with QL=4 -> 4 timing entries retained, t_ovf=1; draining returns the first 4 values in order.
- Assert rst_n=0 during DELAY with 2 entries queued -> z_vld=0 and q_cnt=0 immediately; after release, a new entry with dly=0 is sent normally and t_ovf=0.
- Same stimulus with and without ZSTR_GEN_IDLE_XZ_EN -> z_bus is X vs the held head data while z_vld=0.
